quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature decoder front end for the up/down position counter path. Samples the asynchronous A/B channels of an incremental encoder, synchronizes and optionally deglitches them, decodes Gray-code transitions into single-cycle step/direction pulses, and keeps a loadable wrap-around position count. Sits between the encoder pins and any consumer of up/down step commands.

## Interface
- WIDTH, 4: width of position count q and jump
- FILTER_LEN, 3: consecutive stable cycles needed to accept a new channel level (filter build only; legal 1..15)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low
- enable  input  1  1 = steps counted and reported; 0 = tracking only
- a_in  input  1  encoder channel A, asynchronous
- b_in  input  1  encoder channel B, asynchronous
- load  input  1  load q from jump on next edge
- jump  input  WIDTH  load value
- step  output  1  one-cycle pulse per valid transition
- up_down  output  1  direction of last step: 1 = up, 0 = down
- err  output  1  one-cycle pulse on illegal transition (both channels changed)
- q  output  WIDTH  position count

## Operation
- Reset (reset==0 at a clk edge): q=0, step=0, up_down=0, err=0, synchronizer flops=0, filter state=0, prev={0,0}, FSM=WARMUP, warmup counter=0.
- Synchronizer: two flops per channel; output pair s={a,b}.
- Filtered pair f: equals s (no filter) or filter output (see Configuration).
- FSM WARMUP: lasts W cycles after reset release, W=3 (no filter) or 3+FILTER_LEN (filter). Each cycle prev<=f; step=0, err=0, q holds (load still honoured). After W cycles -> TRACK.
- FSM TRACK: compare f with prev, then prev<=f every cycle.
  - Up sequence 00->01->11->10->00: step=1, up_down=1.
  - Reverse of above: step=1, up_down=0.
  - f==prev: step=0, up_down holds.
  - Both bits differ: err=1, step=0, up_down holds, q holds.
- enable==0: prev still tracks f; step and err forced 0; q holds except load. No spurious step on re-enable.
- q update, priority: load (q<=jump) > step up (q<=q+1) > step down (q<=q-1). Arithmetic modulo 2^WIDTH: all-ones+1=0, 0-1=all-ones.
- load with simultaneous step: q<=jump; step/up_down still reported.
- Reset mid-operation: all state returns to reset values on that edge; WARMUP restarts.

## Timing
- Registered outputs only; no combinational input-to-output paths.
- Latency (no filter): a_in/b_in change captured at edge N -> step/err/q update visible after edge N+2.
- Filter build: add FILTER_LEN cycles.
- Max input rate: one channel transition per (FILTER_LEN+1) cycles (filter) or per 2 cycles (no filter); faster input may yield err.
- step never asserted on two consecutive cycles in filter build with FILTER_LEN>=2.

## Configuration
- QUAD_DECODER_FILTER_EN defined: per-channel filter; filtered level changes only after s differs from current filtered level for FILTER_LEN consecutive cycles; any return to the old level resets the run counter. Filtered level resets to 0.
- Not defined: f=s directly; FILTER_LEN ignored; filter logic absent.

## Structure
- Package quad_decoder_pkg: FSM state enum (WARMUP, TRACK), 2-bit Gray phase constants (PH0=00, PH1=01, PH2=11, PH3=10), SYNC_STAGES=2, base warmup constant 3.
- Sub-module quad_filter: one instance per channel, counter + level register, parameter FILTER_LEN; instantiated only under QUAD_DECODER_FILTER_EN.

## Test plan
- Reset with a_in=1,b_in=1 held, release, wait W cycles -> no step, no err, q=0.
- No filter, enable=1, drive 00->01->11->10->00 one change per 4 cycles -> four step pulses, up_down=1, q=4; reverse sequence -> q=0, up_down=0.
- q=0, one down step -> q=15 (WIDTH=4); load jump=15, one up step -> q=0.
- Jump from 00 to 11 in one cycle -> err pulse for one cycle, step=0, q unchanged.
- Filter build FILTER_LEN=3: 2-cycle glitch on a_in -> no step; 3-cycle-stable change -> one step 5 cycles after input edge.
- enable=0 during two up transitions, then enable=1 with no input change -> no step, q unchanged; load asserted same cycle as up step, jump=9 -> q=9, step=1.

Source files
------------

// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - shared types and constants for the quadrature decoder
package quad_decoder_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    TRACK  = 1'b1
  } state_e;

  // Gray phases in "up" order, packed as {a, b}
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  localparam int SYNC_STAGES = 2;
  localparam int WARMUP_BASE = 3;

  // Position of a Gray phase in the up sequence; differences mod 4 give direction
  function automatic logic [1:0] phase_index(input logic [1:0] ph);
    case (ph)
      PH0:     return 2'd0;
      PH1:     return 2'd1;
      PH2:     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder pins, control and step/position outputs
interface quad_decoder_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             a_in;
  logic             b_in;
  logic             load;
  logic [WIDTH-1:0] jump;
  logic             step;
  logic             up_down;
  logic             err;
  logic [WIDTH-1:0] q;

  modport master (
    output enable, a_in, b_in, load, jump,
    input  step, up_down, err, q
  );

  modport slave (
    input  enable, a_in, b_in, load, jump,
    output step, up_down, err, q
  );
endinterface

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - per-channel deglitcher, level moves after FILTER_LEN stable cycles
module quad_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;

  // Count consecutive cycles where the input disagrees with the held level
  always_comb begin
    cnt_d   = 4'd0;
    level_d = level_q;
    if (din != level_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        level_d = din;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Filter state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder top; QUAD_DECODER_FILTER_EN adds input deglitch filters
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 3
) (
  input logic           clk,
  input logic           reset,
  quad_decoder_if.slave bus
);

`ifdef QUAD_DECODER_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Warmup covers the synchronizer fill, any filter delay and one prev capture
  localparam int WARMUP_CYCLES = WARMUP_BASE + (FILTER_EN ? FILTER_LEN : 0);

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]       s;
  logic [1:0]       f;
  logic [1:0]       prev_q, prev_d;
  state_e           state_q, state_d;
  logic [4:0]       wcnt_q, wcnt_d;
  logic             step_q, step_d;
  logic             up_down_q, up_down_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       delta;

  // Shift the raw {a, b} pins through the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {bus.a_in, bus.b_in}};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef QUAD_DECODER_FILTER_EN
  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_a (
    .clk  (clk),
    .reset(reset),
    .din  (s[1]),
    .dout (f[1])
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_b (
    .clk  (clk),
    .reset(reset),
    .din  (s[0]),
    .dout (f[0])
  );
`else
  assign f = s;
`endif

  // Phase distance mod 4: 1 = up, 3 = down, 2 = both channels flipped
  assign delta = phase_index(f) - phase_index(prev_q);

  // Warmup/track sequencing, transition decode and position update
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    prev_d    = f;
    step_d    = 1'b0;
    err_d     = 1'b0;
    up_down_d = up_down_q;
    q_d       = q_q;

    case (state_q)
      WARMUP: begin
        if (wcnt_q == 5'(WARMUP_CYCLES - 1)) begin
          state_d = TRACK;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      TRACK: begin
        if (bus.enable) begin
          case (delta)
            2'd1: begin
              step_d    = 1'b1;
              up_down_d = 1'b1;
            end
            2'd3: begin
              step_d    = 1'b1;
              up_down_d = 1'b0;
            end
            2'd2:    err_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = WARMUP;
    endcase

    if (bus.load) begin
      q_d = bus.jump;
    end else if (step_d) begin
      q_d = up_down_d ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      prev_q    <= 2'b00;
      state_q   <= WARMUP;
      wcnt_q    <= 5'd0;
      step_q    <= 1'b0;
      up_down_q <= 1'b0;
      err_q     <= 1'b0;
      q_q       <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      step_q    <= step_d;
      up_down_q <= up_down_d;
      err_q     <= err_d;
      q_q       <= q_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.up_down = up_down_q;
  assign bus.err     = err_q;
  assign bus.q       = q_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int FL    = 3;
`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT = 2 + FL;
`else
  localparam int LAT = 2;
`endif
  localparam int GAP = LAT + 4;

  typedef struct packed {
    logic             step;
    logic             err;
    logic             up_down;
    logic [WIDTH-1:0] q;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ev_t  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every step/err pulse must match the next queued expectation
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (reset === 1'b1 && (bus.step === 1'b1 || bus.err === 1'b1)) begin
      act = {bus.step, bus.err, bus.up_down, bus.q};
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 32'(act), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  task automatic move(input logic [1:0] ab, input logic s, input logic e,
                      input logic ud, input logic [WIDTH-1:0] qv);
    if (s || e) exp_q.push_back({s, e, ud, qv});
    set_ab(ab);
    repeat (GAP) tick();
  endtask

  task automatic measure(input string name, input logic [1:0] ab,
                         input logic ud, input logic [WIDTH-1:0] qv);
    int k;
    exp_q.push_back({1'b1, 1'b0, ud, qv});
    set_ab(ab);
    for (k = 1; k <= 20; k++) begin
      tick();
      if (bus.step === 1'b1 || bus.err === 1'b1) break;
    end
    check(name, 32'(k - 1), 32'(LAT));
    repeat (GAP) tick();
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.load   = 1'b0;
    bus.jump   = '0;
    set_ab(2'b11);
    reset = 1'b0;
    repeat (3) tick();
    check("reset_step", 32'(bus.step), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_up_down", 32'(bus.up_down), 32'd0);
    check("reset_q", 32'(bus.q), 32'd0);

    reset = 1'b1;
    repeat (LAT + 6) tick();
    check("warmup_q", 32'(bus.q), 32'd0);

    measure("latency_up", 2'b10, 1'b1, 4'd1);
    move(2'b00, 1'b1, 1'b0, 1'b1, 4'd2);
    bus.jump = 4'd0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("load_zero", 32'(bus.q), 32'd0);

    move(2'b01, 1'b1, 1'b0, 1'b1, 4'd1);
    move(2'b11, 1'b1, 1'b0, 1'b1, 4'd2);
    move(2'b10, 1'b1, 1'b0, 1'b1, 4'd3);
    move(2'b00, 1'b1, 1'b0, 1'b1, 4'd4);
    check("up_seq_q", 32'(bus.q), 32'd4);
    check("up_seq_dir", 32'(bus.up_down), 32'd1);

    move(2'b10, 1'b1, 1'b0, 1'b0, 4'd3);
    move(2'b11, 1'b1, 1'b0, 1'b0, 4'd2);
    move(2'b01, 1'b1, 1'b0, 1'b0, 4'd1);
    move(2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
    check("down_seq_q", 32'(bus.q), 32'd0);
    check("down_seq_dir", 32'(bus.up_down), 32'd0);

    move(2'b10, 1'b1, 1'b0, 1'b0, 4'd15);
    check("underflow_q", 32'(bus.q), 32'd15);
    bus.jump = 4'd15;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    move(2'b00, 1'b1, 1'b0, 1'b1, 4'd0);
    check("overflow_q", 32'(bus.q), 32'd0);

    move(2'b11, 1'b0, 1'b1, 1'b1, 4'd0);
    check("err_q_hold", 32'(bus.q), 32'd0);
    move(2'b10, 1'b1, 1'b0, 1'b1, 4'd1);

    bus.enable = 1'b0;
    move(2'b00, 1'b0, 1'b0, 1'b1, 4'd1);
    move(2'b01, 1'b0, 1'b0, 1'b1, 4'd1);
    bus.enable = 1'b1;
    repeat (GAP) tick();
    check("reenable_q", 32'(bus.q), 32'd1);

    exp_q.push_back({1'b1, 1'b0, 1'b1, 4'd9});
    set_ab(2'b11);
    repeat (LAT) tick();
    bus.jump = 4'd9;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("load_step_q", 32'(bus.q), 32'd9);
    check("load_step_step", 32'(bus.step), 32'd1);
    repeat (GAP) tick();

`ifdef QUAD_DECODER_FILTER_EN
    set_ab(2'b01);
    repeat (2) tick();
    set_ab(2'b11);
    repeat (GAP) tick();
    check("glitch_q", 32'(bus.q), 32'd9);
    measure("filter_latency", 2'b01, 1'b0, 4'd8);
`endif

    reset = 1'b0;
    tick();
    check("mid_reset_q", 32'(bus.q), 32'd0);
    check("mid_reset_dir", 32'(bus.up_down), 32'd0);
    reset = 1'b1;
    repeat (GAP + FL) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
